// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: prefetch depth, count encoding, default word width.
package async_fifo_pkg;

    localparam int PF_DEPTH            = 2;
    localparam int ASYNC_FIFO_DATASIZE = 8;

    typedef enum logic [1:0] {
        PF_EMPTY = 2'd0,
        PF_ONE   = 2'd1,
        PF_TWO   = 2'd2
    } pf_cnt_e;

endpackage

// File: rtl/async_fifo_rd_prefetch.sv
// Read-side 2-entry FWFT prefetch; word visible 1 cycle after rinc, rinc never depends on out_ready.
// Holds out_data stable under backpressure; ASYNC_FIFO_RD_PREFETCH_STATS_EN adds rd_count pop counter.
module async_fifo_rd_prefetch
    import async_fifo_pkg::*;
#(
    parameter int DATASIZE = ASYNC_FIFO_DATASIZE
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef ASYNC_FIFO_RD_PREFETCH_STATS_EN
    output logic [31:0]         rd_count,
`endif
    output logic [DATASIZE-1:0] out_data
);

    logic [DATASIZE-1:0] slot0_q, slot0_d;
    logic [DATASIZE-1:0] slot1_q, slot1_d;
    pf_cnt_e             count_q, count_d;
    logic                push;
    logic                pop;

    // Push only looks at our own occupancy, so consumer timing stays off the pointer path.
    assign rinc      = ~rempty & (count_q != PF_TWO);
    assign push      = rinc;
    assign out_valid = (count_q != PF_EMPTY);
    assign pop       = out_valid & out_ready;
    assign out_data  = slot0_q;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case (count_q)
            PF_EMPTY: begin
                if (push) begin
                    slot0_d = rdata;
                    count_d = PF_ONE;
                end
            end
            PF_ONE: begin
                if (push && pop) begin
                    slot0_d = rdata;
                end else if (push) begin
                    slot1_d = rdata;
                    count_d = PF_TWO;
                end else if (pop) begin
                    count_d = PF_EMPTY;
                end
            end
            PF_TWO: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    count_d = PF_ONE;
                end
            end
            default: begin
                count_d = PF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= PF_EMPTY;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

`ifdef ASYNC_FIFO_RD_PREFETCH_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;

    assign rd_count_d = pop ? rd_count_q + 32'd1 : rd_count_q;
    assign rd_count   = rd_count_q;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_rd_prefetch.sv
// Directed bench for the read-side prefetch stage; stats checks only when the macro is defined.
module tb_async_fifo_rd_prefetch;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef ASYNC_FIFO_RD_PREFETCH_STATS_EN
    logic [31:0] rd_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 rclk = ~rclk;

    async_fifo_rd_prefetch #(.DATASIZE(8)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ASYNC_FIFO_RD_PREFETCH_STATS_EN
        .rd_count  (rd_count),
`endif
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    initial begin
        rrst_n    = 1'b0;
        rempty    = 1'b0;
        rdata     = 8'hAA;
        out_ready = 1'b0;

        // reset
        tick(); tick(); tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
`ifdef ASYNC_FIFO_RD_PREFETCH_STATS_EN
        chk("rst_count", rd_count, 32'd0);
`endif
        rrst_n = 1'b1;
        #1;
        chk("rel_rinc", rinc, 1'b1);
        tick();
        chk("first_valid", out_valid, 1'b1);
        chk("first_data", out_data, 8'hAA);
        rempty    = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("first_drain_valid", out_valid, 1'b0);
        chk("first_drain_rinc", rinc, 1'b0);

        // streaming
        rempty = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            rdata = 8'(i);
            tick();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_data", out_data, 8'(i));
            chk("stream_rinc", rinc, 1'b1);
        end
        rempty = 1'b1;
        tick();
        chk("stream_drain", out_valid, 1'b0);

        // backpressure
        out_ready = 1'b0;
        rempty    = 1'b0;
        rdata     = 8'h10;
        tick();
        rdata = 8'h11;
        chk("bp_rinc_c2", rinc, 1'b1);
        tick();
        rdata = 8'h12;
        #1;
        chk("bp_rinc_full", rinc, 1'b0);
        chk("bp_data_full", out_data, 8'h10);
        tick();
        chk("bp_hold_data", out_data, 8'h10);
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_rinc", rinc, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_rinc", rinc, 1'b0);
        tick();
        chk("bp_out1", out_data, 8'h11);
        chk("bp_rinc_reopen", rinc, 1'b1);
        tick();
        chk("bp_out2", out_data, 8'h12);
        chk("bp_out2_valid", out_valid, 1'b1);
        rempty = 1'b1;
        tick();
        chk("bp_drain", out_valid, 1'b0);

        // empty boundary
        out_ready = 1'b0;
        rempty    = 1'b0;
        rdata     = 8'h55;
        tick();
        rempty    = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("emp_data", out_data, 8'h55);
        chk("emp_rinc", rinc, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("emp_valid_low", out_valid, 1'b0);
            chk("emp_rinc_low", rinc, 1'b0);
        end
        rempty = 1'b0;
        rdata  = 8'h56;
        #1;
        chk("emp_rinc_resume", rinc, 1'b1);
        tick();
        chk("emp_resume_data", out_data, 8'h56);
        rempty = 1'b1;
        tick();

        // reset mid-operation
        out_ready = 1'b0;
        rempty    = 1'b0;
        rdata     = 8'h20;
        tick();
        rdata = 8'h21;
        tick();
        chk("mid_full_data", out_data, 8'h20);
        chk("mid_full_rinc", rinc, 1'b0);
        rrst_n = 1'b0;
        rempty = 1'b1;
        tick();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 8'h00);
        rrst_n    = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mid_no_replay", out_valid, 1'b0);
        tick();
        chk("mid_no_replay2", out_valid, 1'b0);

`ifdef ASYNC_FIFO_RD_PREFETCH_STATS_EN
        rrst_n = 1'b0;
        tick();
        chk("st_rst", rd_count, 32'd0);
        rrst_n    = 1'b1;
        rempty    = 1'b0;
        out_ready = 1'b1;
        rdata     = 8'h00;
        tick();
        for (int i = 0; i < 37; i++) begin
            rdata = 8'(i + 1);
            tick();
        end
        chk("st_37", rd_count, 32'd37);
        rempty    = 1'b1;
        out_ready = 1'b0;
        force dut.rd_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_count_q;
        out_ready = 1'b1;
        tick();
        chk("st_wrap", rd_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
